// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Register-hazard scheduler for the MIPS ID stage. It keeps one pending bit
// per GPR that has a long-latency (load) write in flight. Each cycle it decides
// whether the ID instruction may issue or must stall.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   id_valid, id_flush  ID holds a valid instruction / kill it this cycle
//   reg_read_en_1/2     operand read enables
//   reg_addr_1/2        operand GPR addresses
//   reg_write_en        ID instruction writes a GPR
//   reg_write_addr      destination GPR address
//   id_is_load          destination is written with long latency
//   wb_done, wb_addr    long-latency write completion and its GPR
//   stall_req, issue    combinational stall / advance decision
//   pending_mask        registered pending bit per GPR
//   pending_count       registered popcount of pending_mask
//   sb_error            sticky protocol-error flag
module reg_scoreboard #(
  parameter int REG_COUNT   = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_flush,
  input  logic                  reg_read_en_1,
  input  logic [ADDR_WIDTH-1:0] reg_addr_1,
  input  logic                  reg_read_en_2,
  input  logic [ADDR_WIDTH-1:0] reg_addr_2,
  input  logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] reg_write_addr,
  input  logic                  id_is_load,
  input  logic                  wb_done,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  stall_req,
  output logic                  issue,
  output logic [REG_COUNT-1:0]  pending_mask,
  output logic [ADDR_WIDTH:0]   pending_count,
  output logic                  sb_error
);

  localparam logic [ADDR_WIDTH:0] MAX_PEND_C = MAX_PENDING[ADDR_WIDTH:0];

  logic [REG_COUNT-1:0] pending_mask_q, pending_mask_d;
  logic [ADDR_WIDTH:0]  pending_count_q, pending_count_d;
  logic                 sb_error_q, sb_error_d;

  logic [REG_COUNT-1:0] clr, set, eff;
  logic                 clr_any, set_any;
  logic                 hazard;
  logic                 wr_nonzero;
  logic                 wb_unmatched;
  logic [ADDR_WIDTH:0]  count_after_clr;

  always_comb begin
    clr          = '0;
    wb_unmatched = 1'b0;
    if (wb_done && (wb_addr != '0)) begin
      if (pending_mask_q[wb_addr]) clr[wb_addr] = 1'b1;
      else                         wb_unmatched = 1'b1;
    end
    clr_any = (clr != '0);
    // A completing write is forwarded in its own cycle, so it must not hazard.
    eff = pending_mask_q & ~clr;
  end

  always_comb begin
    wr_nonzero      = reg_write_en && (reg_write_addr != '0);
    count_after_clr = pending_count_q - {{ADDR_WIDTH{1'b0}}, clr_any};
    hazard = 1'b0;
    if (reg_read_en_1 && (reg_addr_1 != '0) && eff[reg_addr_1]) hazard = 1'b1;
    if (reg_read_en_2 && (reg_addr_2 != '0) && eff[reg_addr_2]) hazard = 1'b1;
    if (wr_nonzero && eff[reg_write_addr])                      hazard = 1'b1;
    // Capacity only limits loads; a completion this cycle frees one slot.
    if (id_is_load && wr_nonzero && (count_after_clr == MAX_PEND_C)) hazard = 1'b1;

    stall_req = id_valid && !id_flush && hazard;
    issue     = id_valid && !id_flush && !hazard;
  end

  always_comb begin
    set = '0;
    if (issue && id_is_load && wr_nonzero) set[reg_write_addr] = 1'b1;
    set_any = (set != '0);

    // Set after clear: a load re-targeting a completing register keeps the bit.
    pending_mask_d  = (pending_mask_q & ~clr) | set;
    pending_count_d = pending_count_q + {{ADDR_WIDTH{1'b0}}, set_any}
                                      - {{ADDR_WIDTH{1'b0}}, clr_any};
    sb_error_d      = sb_error_q || wb_unmatched || (pending_count_q > MAX_PEND_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_mask_q  <= '0;
      pending_count_q <= '0;
      sb_error_q      <= 1'b0;
    end else begin
      pending_mask_q  <= pending_mask_d;
      pending_count_q <= pending_count_d;
      sb_error_q      <= sb_error_d;
    end
  end

  assign pending_mask  = pending_mask_q;
  assign pending_count = pending_count_q;
  assign sb_error      = sb_error_q;

endmodule
